// File: rtl/gray_counter_n.sv
// Parametrised Gray-code up/down counter with wrap/saturate mode, sticky end-of-range flags and event tick.
// Optional Gray-value load path enabled by defining GRAY_LOAD_EN.
module gray_counter_n #(
    parameter int WIDTH = 3,
    parameter bit WRAP  = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Up,
    input  logic             Clr,
    input  logic             FlagClr,
`ifdef GRAY_LOAD_EN
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
`endif
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Tick
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             tick_q, tick_d;
    logic             load_act;
    logic [WIDTH-1:0] load_bin;

`ifdef GRAY_LOAD_EN
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign load_act = Load;
    assign load_bin = gray2bin(LoadGray);
`else
    assign load_act = 1'b0;
    assign load_bin = '0;
`endif

    always_comb begin
        bin_d  = bin_q;
        tick_d = 1'b0;
        // A new event in the same cycle overrides FlagClr for its own flag.
        ovf_d  = ovf_q & ~FlagClr;
        unf_d  = unf_q & ~FlagClr;
        if (Clr) begin
            bin_d = '0;
        end else if (load_act) begin
            bin_d = load_bin;
        end else if (En) begin
            if (Up) begin
                if (bin_q == MAX) begin
                    ovf_d  = 1'b1;
                    tick_d = 1'b1;
                    bin_d  = WRAP ? '0 : MAX;
                end else begin
                    bin_d = bin_q + WIDTH'(1);
                end
            end else begin
                if (bin_q == '0) begin
                    unf_d  = 1'b1;
                    tick_d = 1'b1;
                    bin_d  = WRAP ? MAX : '0;
                end else begin
                    bin_d = bin_q - WIDTH'(1);
                end
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            tick_q <= tick_d;
        end
    end

    assign Output    = gray_q;
    assign Binary    = bin_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Tick      = tick_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: a WIDTH=3 wrapping instance and a WIDTH=4 saturating instance
// share stimulus; expected results are queued per edge and popped by a negedge monitor.
module tb_gray_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, up, clr, fclr;
`ifdef GRAY_LOAD_EN
    logic       ld;
    logic [2:0] lg3;
    logic [3:0] lg4;
`endif
    logic [2:0] g3, b3;
    logic [3:0] g4, b4;
    logic       ov3, un3, tk3, ov4, un4, tk4;

    gray_counter_n #(.WIDTH(3), .WRAP(1'b1)) dut3 (
        .Clk(clk), .Reset_n(rst_n), .En(en), .Up(up), .Clr(clr), .FlagClr(fclr),
`ifdef GRAY_LOAD_EN
        .Load(ld), .LoadGray(lg3),
`endif
        .Output(g3), .Binary(b3), .Overflow(ov3), .Underflow(un3), .Tick(tk3)
    );

    gray_counter_n #(.WIDTH(4), .WRAP(1'b0)) dut4 (
        .Clk(clk), .Reset_n(rst_n), .En(en), .Up(up), .Clr(clr), .FlagClr(fclr),
`ifdef GRAY_LOAD_EN
        .Load(ld), .LoadGray(lg4),
`endif
        .Output(g4), .Binary(b4), .Overflow(ov4), .Underflow(un4), .Tick(tk4)
    );

    typedef struct {
        int g;
        int b;
        bit ov;
        bit un;
        bit tk;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];
    int checks = 0;
    int errors = 0;

    // Reference model: instance 0 = width 3 wrapping, instance 1 = width 4 saturating
    int mb[2];
    bit mov[2], mun[2], mtk[2];
    int mw[2]    = '{3, 4};
    bit mwrap[2] = '{1'b1, 1'b0};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Binary value whose Gray code is g: XOR of all right shifts of g.
    function automatic int from_gray(input int g);
        int b = 0;
        for (int k = 0; k < 8; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mb[i] = 0; mov[i] = 0; mun[i] = 0; mtk[i] = 0;
        end
    endfunction

    function automatic void model_edge(input int i, input bit e, input bit u, input bit c,
                                       input bit f, input bit l, input int lgv);
        int mx = (1 << mw[i]) - 1;
        mtk[i] = 0;
        if (f) begin
            mov[i] = 0;
            mun[i] = 0;
        end
        if (c) mb[i] = 0;
        else if (l) mb[i] = from_gray(lgv);
        else if (e) begin
            if (u) begin
                if (mb[i] == mx) begin
                    mov[i] = 1; mtk[i] = 1;
                    mb[i] = mwrap[i] ? 0 : mx;
                end else mb[i] = mb[i] + 1;
            end else begin
                if (mb[i] == 0) begin
                    mun[i] = 1; mtk[i] = 1;
                    mb[i] = mwrap[i] ? mx : 0;
                end else mb[i] = mb[i] - 1;
            end
        end
    endfunction

    function automatic exp_t snap(input int i);
        exp_t e;
        e.b = mb[i]; e.g = to_gray(mb[i]); e.ov = mov[i]; e.un = mun[i]; e.tk = mtk[i];
        return e;
    endfunction

    // One clock: drive at negedge, update model and queue expectation just after posedge.
    task automatic step(input bit r, input bit e, input bit u, input bit c, input bit f,
                        input bit l = 1'b0, input int l3 = 0, input int l4 = 0);
        @(negedge clk);
        rst_n = r; en = e; up = u; clr = c; fclr = f;
`ifdef GRAY_LOAD_EN
        ld = l; lg3 = 3'(l3); lg4 = 4'(l4);
`endif
        @(posedge clk);
        #1;
        if (!r) model_reset();
        else begin
            model_edge(0, e, u, c, f, l, l3);
            model_edge(1, e, u, c, f, l, l4);
        end
        q3.push_back(snap(0));
        q4.push_back(snap(1));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("w3_gray", int'(g3), e.g);
                chk("w3_bin", int'(b3), e.b);
                chk("w3_ovf", int'(ov3), int'(e.ov));
                chk("w3_unf", int'(un3), int'(e.un));
                chk("w3_tick", int'(tk3), int'(e.tk));
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("w4_gray", int'(g4), e.g);
                chk("w4_bin", int'(b4), e.b);
                chk("w4_ovf", int'(ov4), int'(e.ov));
                chk("w4_unf", int'(un4), int'(e.un));
                chk("w4_tick", int'(tk4), int'(e.tk));
            end
        end
    end

    int up_seq[9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};

    initial begin : stimulus
        bit l;
        rst_n = 1'b1; en = 0; up = 0; clr = 0; fclr = 0;
`ifdef GRAY_LOAD_EN
        ld = 0; lg3 = 0; lg4 = 0;
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("reset_gray", int'(g3), 0);
        chk("reset_bin", int'(b4), 0);
        chk("reset_flags", int'({ov3, un3, tk3, ov4, un4, tk4}), 0);
        model_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);

        // Count up from reset; wrap step sets Overflow and pulses Tick
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 1, 0, 0);
            if (i < 8) chk("up_seq_gray", int'(g3), up_seq[i] == 1 && i == 8 ? 1 : up_seq[i]);
            if (i == 7) begin
                chk("wrap_tick", int'(tk3), 1);
                chk("wrap_ovf", int'(ov3), 1);
            end
            if (i == 8) begin
                chk("tick_one_cycle", int'(tk3), 0);
                chk("ovf_sticky", int'(ov3), 1);
            end
        end

        // Down wrap from 0, then FlagClr
        step(1, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0);
        chk("down_bin", int'(b3), 7);
        chk("down_gray", int'(g3), 4);
        chk("down_unf", int'(un3), 1);
        step(1, 0, 0, 0, 1);
        chk("flagclr_unf", int'(un3), 0);

        // Saturation on the width-4 instance: 15 steps to MAX then two more
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 1, 0, 0);
            if (i >= 15) begin
                chk("sat_bin", int'(b4), 15);
                chk("sat_gray", int'(g4), 8);
                chk("sat_tick", int'(tk4), 1);
            end
        end

        // Overflow event coincident with FlagClr; Clr with En gives no Tick
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 1);
        chk("evt_beats_flagclr", int'(ov3), 1);
        chk("evt_wrap_bin", int'(b3), 0);
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        chk("clr_en_bin", int'(b3), 0);
        chk("clr_en_tick", int'(tk3), 0);

`ifdef GRAY_LOAD_EN
        step(1, 0, 0, 0, 0, 1, 3'b110, 4'b1100);
        chk("load_bin", int'(b4), 8);
        chk("load_gray", int'(g4), 12);
        step(1, 1, 1, 0, 0);
        chk("load_step_bin", int'(b4), 9);
        chk("load_step_gray", int'(g4), 13);
        step(1, 0, 0, 1, 0, 1, 3'b101, 4'b1111);
        chk("clr_beats_load", int'(b4), 0);
`endif

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            l = 1'b0;
`ifdef GRAY_LOAD_EN
            l = ($urandom_range(0, 15) == 0);
`endif
            step(1, ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                 l, $urandom_range(0, 7), $urandom_range(0, 15));
        end

        // Asynchronous reset between edges at B=5
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
        chk("pre_reset_bin", int'(b3), 5);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_bin", int'(b3), 0);
        chk("async_gray", int'(g3), 0);
        chk("async_flags", int'({ov3, un3, tk3, ov4, un4, tk4, 4'(b4)}), 0);
        model_reset();
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        chk("resume_bin", int'(b3), 3);

        @(negedge clk);
        #1;
        chk("queue_drained", q3.size() + q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code up/down counter. It generalises the fixed 3-bit up-only Gray counter to any width. It adds a direction control, a wrap or saturate mode, sticky overflow and underflow flags with clear, an event pulse, and an optional Gray-value load. It sits in the pre/P1 sequential-logic library and can be used as a standalone counter or as a pointer generator for later FIFO work.

## Interface

Parameters:
- WIDTH, 3, counter width in bits; legal values ≥2.
- WRAP, 1, 1 = wrap around at the end of the range; 0 = saturate at the end of the range.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- En  input  1  count enable; one step per cycle while high.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Clr  input  1  synchronous clear of the count only; flags are not affected.
- FlagClr  input  1  synchronous clear of Overflow and Underflow.
- Load  input  1  synchronous load; present only with GRAY_LOAD_EN.
- LoadGray  input  WIDTH  Gray value to load; present only with GRAY_LOAD_EN.
- Output  output  WIDTH  registered Gray code of the count.
- Binary  output  WIDTH  registered binary count.
- Overflow  output  1  sticky; set on any up-step from the maximum value.
- Underflow  output  1  sticky; set on any down-step from 0.
- Tick  output  1  one-cycle pulse on each overflow or underflow event.

## Operation

- Internal state is the binary count B (WIDTH bits). Output = B ^ (B >> 1). Both Output and Binary are registered.
- Per-edge priority: Clr > Load > En.
  - Clr: B←0. Tick←0.
  - Load: B←gray2bin(LoadGray). Tick←0.
  - En, Up=1, B<MAX: B←B+1.
  - En, Up=0, B>0: B←B−1.
  - En, neither: B holds.
- MAX = 2^WIDTH−1.
- End-of-range events:
  - En & Up & B==MAX: set Overflow and pulse Tick. B←0 if WRAP=1; B holds at MAX if WRAP=0.
  - En & !Up & B==0: set Underflow and pulse Tick. B←MAX if WRAP=1; B holds at 0 if WRAP=0.
  - Saturate mode (WRAP=0) re-flags and re-pulses Tick on every further attempt to step past the end.
- Flag clear:
  - FlagClr clears both sticky flags.
  - If FlagClr coincides with a new event, the event wins and the corresponding flag is 1 after the edge.
  - Clr and Load never touch the flags.
- The count arithmetic wraps modulo 2^WIDTH. No carry leaks into any other output.
- gray2bin: b[WIDTH−1]=g[WIDTH−1]; b[i]=b[i+1]^g[i].

## Timing

- All outputs change only on the rising edge of Clk, or asynchronously when Reset_n falls.
- Latency: inputs sampled at edge N are reflected on Output, Binary, Overflow, Underflow and Tick immediately after edge N.
- Tick is high for exactly the one cycle following the event edge.
- Reset values (Reset_n=0): Output=0, Binary=0, Overflow=0, Underflow=0, Tick=0. Outputs clear immediately, with no clock needed.
- Reset asserted mid-count discards the count and the flags.
- The first edge with Reset_n=1 acts on the sampled inputs normally. Reset_n deassertion must be synchronous to Clk; this is the integrator's responsibility.
- Consecutive Output values differ in exactly one bit for every En step, including the wrap step. Load and Clr steps are exempt.

## Configuration

- GRAY_LOAD_EN defined: the Load and LoadGray ports exist, and the load path is active at priority 2.
- GRAY_LOAD_EN undefined: the Load and LoadGray ports and the gray2bin logic are absent. Priority is Clr > En. All other behaviour is identical.

## Test plan

- Reset and count up (WIDTH=3, WRAP=1): hold Reset_n=0, then release and assert En=1, Up=1 for 9 edges.
  - During reset, all outputs = 0.
  - Output sequence: 0,1,3,2,6,7,5,4,0.
  - On the 8th step, Overflow=1 and Tick=1 for one cycle. Overflow stays 1 afterwards.
- Down wrap (WIDTH=3): from reset, En=1, Up=0 for one edge.
  - Result: Binary=7, Output=4, Underflow=1, Tick pulse.
  - Then pulse FlagClr: Underflow=0.
- Saturate (WIDTH=4, WRAP=0): count up to 15, then apply 2 more up-steps.
  - Binary holds at 15 and Output holds at 8.
  - Tick pulses on both extra edges. Overflow=1.
- Load (GRAY_LOAD_EN, WIDTH=4): Load=1, LoadGray=4'b1100, then En=1, Up=1 for one edge.
  - After the load: Binary=8, Output=12.
  - After the step: Binary=9, Output=13.
  - Load and Clr asserted together: Clr wins and Binary=0.
- Simultaneous events (WIDTH=3, B=7): En=1, Up=1 and FlagClr=1 on the same edge.
  - Result: Overflow=1 and B=0.
  - Clr asserted with En on the same edge: B=0 and no Tick.
- Async reset mid-count: drop Reset_n between clock edges at B=5.
  - All outputs read 0 before the next edge.
  - After release, counting resumes from 0.
